uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit serializer; sits directly downstream of the TX baud generator. Accepts a parallel word through a start/busy handshake, drives the generator's baud_en input, and shifts out one frame on tx: start bit, data LSB-first, optional parity, 1 or 2 stop bits. It advances one bit per rising edge of tx_tick and idles the line high.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity and 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; the same clock that drives the baud generator.
rst  input  1  asynchronous, active-low reset.
tx_tick  input  1  bit strobe from the baud generator.
data_in  input  DATA_BITS  word to transmit; sampled on accept.
tx_start  input  1  transmit request; sampled every clk.
baud_en  output  1  enable to the baud generator.
tx  output  1  serial line; idle level is high.
tx_busy  output  1  high while a frame is in progress.
tx_done  output  1  one-clk pulse after the final stop bit completes.

Behaviour:
- Reset (async, rst=0): state=IDLE; tx=1, tx_busy=0, tx_done=0, baud_en=0; shift register, bit counter and tick_q cleared. Reset mid-frame aborts the frame immediately and the line returns high.
- Tick qualification: tick_q is a registered copy of tx_tick. adv = tx_tick & ~tick_q. Only adv advances the FSM, so a tx_tick held high counts as a single bit boundary.
- Accept: in IDLE, tx_start=1 at a clk edge latches data_in into the shift register and computes parity = ^data_in ^ PARITY_ODD. On the same edge: state→START, tx=0, tx_busy=1, baud_en=1. The start bit appears one clk after tx_start is sampled.
- tx_start while tx_busy=1 is ignored and does not queue. data_in changes after accept have no effect.
- FSM states are IDLE, START, DATA, PARITY, STOP. All transitions below occur on adv only.
  - START→DATA: tx=shift[0].
  - DATA: on each adv, shift right and increment bit_cnt. After DATA_BITS bits go to PARITY (tx=parity) if PARITY_EN=1, else to STOP (tx=1).
  - PARITY→STOP: tx=1.
  - STOP: stays for STOP_BITS adv events. The final adv sets state=IDLE, tx_busy=0, baud_en=0, and pulses tx_done=1 for exactly one clk.
- Bit period equals the spacing between qualified ticks. The first (start) bit may be up to 1 clk shorter than nominal because the generator counter is not cleared on disable. The bench must allow ±1 clk on the start bit only.
- tx_start asserted in the same cycle tx_done pulses (state is already IDLE) is accepted on the next edge. Back-to-back frames are therefore separated by exactly one idle-high clk.
- Frame length in ticks: 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- tx and tx_busy are registered outputs, so they are glitch-free. baud_en equals tx_busy.
- bit_cnt width is $clog2(DATA_BITS+1). Wrap is not possible because the counter is cleared on every accept.

Test Plan:
1. Reset, then send one byte (generator configured for 16 clk/bit, defaults, data_in=0xA5) → tx=0 for 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then 1 for 16 clk. tx_done pulses once and tx_busy falls in the same cycle.
2. Parity (PARITY_EN=1, PARITY_ODD=0, data_in=0xA5) → parity bit=0. With PARITY_ODD=1 → parity bit=1. For data_in=0x01 with even parity → parity bit=1.
3. Two stop bits (STOP_BITS=2, data_in=0x00) → 8 zero data bits, then 32 clk high before tx_done. Total frame is 11 ticks.
4. Busy protection: pulse tx_start with 0x3C mid-frame while sending 0xA5 → only 0xA5 is transmitted and no second frame follows.
5. Back-to-back: hold tx_start=1 with 0x55 then 0xAA → two frames separated by exactly one idle clk. Both decode correctly.
6. Async reset mid-DATA (rst low for 3 clk, no clk edge needed) → tx=1, tx_busy=0, baud_en=0 immediately. A following frame with 0x0F transmits correctly.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// +----------------------------------------------------------------------------+
// | uart_tx_serializer: UART frame serializer driven by baud-generator ticks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_tick,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_start,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick_q;
  logic                 adv;

  // A held-high tick only counts once: advance on its rising edge.
  assign adv = tx_tick & ~tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tick_q    <= tx_tick;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d   = data_in;
          parity_d  = (^data_in) ^ 1'(PARITY_ODD);
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (adv) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (adv) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // tx already shows shift_q[0]; the next bit sits one place up.
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (adv) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (adv) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign baud_en = busy_q;
  assign tx_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_serializer: directed bench for uart_tx_serializer variants.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_serializer;

  // Instance 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits.
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tick_v;
  logic [3:0] start_v;
  logic [3:0] baud_en_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] din_v [4];
  logic [3:0] gen_cnt [4];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Baud generator model: 16 clk per bit, counter holds while disabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) gen_cnt[k] <= 4'd0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (baud_en_v[k]) gen_cnt[k] <= gen_cnt[k] + 4'd1;
    end
  end

  always_comb begin
    tick_v = '0;
    for (int k = 0; k < 4; k++) tick_v[k] = baud_en_v[k] && (gen_cnt[k] == 4'd15);
  end

  uart_tx_serializer u_dut (
    .clk(clk), .rst(rst), .tx_tick(tick_v[0]), .data_in(din_v[0]), .tx_start(start_v[0]),
    .baud_en(baud_en_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0])
  );

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
    .clk(clk), .rst(rst), .tx_tick(tick_v[1]), .data_in(din_v[1]), .tx_start(start_v[1]),
    .baud_en(baud_en_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1])
  );

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
    .clk(clk), .rst(rst), .tx_tick(tick_v[2]), .data_in(din_v[2]), .tx_start(start_v[2]),
    .baud_en(baud_en_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2])
  );

  uart_tx_serializer #(.STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .tx_tick(tick_v[3]), .data_in(din_v[3]), .tx_start(start_v[3]),
    .baud_en(baud_en_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_pulse(input int k, input logic [7:0] d);
    din_v[k]   = d;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // Samples tx once per clk until tx_done; checks length and each bit centre.
  // exp holds the frame bits in line order (bit 0 = start bit).
  task automatic capture(input int k, input int nb, input logic [11:0] exp,
                         input string tag, input bit inject);
    logic s [256];
    int   d;
    d = -1;
    for (int i = 0; i < 256; i++) begin
      s[i] = tx_v[k];
      if (done_v[k]) begin
        d = i;
        break;
      end
      if (inject && i == 40) begin
        din_v[k]   = 8'h3C;
        start_v[k] = 1'b1;
      end
      if (inject && i == 41) start_v[k] = 1'b0;
      @(negedge clk);
    end
    if (d < 0) begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " len"}, 32'(d >= 16 * nb - 1 && d <= 16 * nb), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy_v[k]), 32'd0);
    chk({tag, " baud_en_at_done"}, 32'(baud_en_v[k]), 32'd0);
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s bit%0d", tag, b), 32'(s[d - 16 * (nb - b) + 8]), 32'(exp[b]));
  endtask

  initial begin
    int lows;
    rst     = 1'b0;
    start_v = '0;
    for (int k = 0; k < 4; k++) din_v[k] = 8'h00;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset tx%0d", k), 32'(tx_v[k]), 32'd1);
      chk($sformatf("reset busy%0d", k), 32'(busy_v[k] | baud_en_v[k] | done_v[k]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Single default frame plus tx_done width.
    start_pulse(0, 8'hA5);
    capture(0, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, "a5", 1'b0);
    @(negedge clk);
    chk("done one clk", 32'(done_v[0]), 32'd0);
    chk("idle line", 32'(tx_v[0]), 32'd1);

    // Parity variants: A5 even -> 0, 01 even -> 1, A5 odd -> 1.
    start_pulse(1, 8'hA5);
    capture(1, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, "par_even_a5", 1'b0);
    @(negedge clk);
    start_pulse(1, 8'h01);
    capture(1, 11, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, "par_even_01", 1'b0);
    @(negedge clk);
    start_pulse(2, 8'hA5);
    capture(2, 11, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, "par_odd_a5", 1'b0);

    // Two stop bits.
    @(negedge clk);
    start_pulse(3, 8'h00);
    capture(3, 11, {1'b0, 2'b11, 8'h00, 1'b0}, "stop2", 1'b0);

    // Request during a frame is dropped.
    @(negedge clk);
    start_pulse(0, 8'hA5);
    capture(0, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, "busy_a5", 1'b1);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (!tx_v[0] || busy_v[0]) lows++;
    end
    chk("no queued frame", 32'(lows), 32'd0);

    // Back-to-back with tx_start held high.
    din_v[0]   = 8'h55;
    start_v[0] = 1'b1;
    @(negedge clk);
    din_v[0] = 8'hAA;
    capture(0, 10, {2'b00, 1'b1, 8'h55, 1'b0}, "b2b_55", 1'b0);
    chk("b2b gap high", 32'(tx_v[0]), 32'd1);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b restart", 32'({tx_v[0], busy_v[0]}), 32'b01);
    capture(0, 10, {2'b00, 1'b1, 8'hAA, 1'b0}, "b2b_aa", 1'b0);

    // Asynchronous reset in the middle of the data bits.
    @(negedge clk);
    start_pulse(0, 8'hA5);
    repeat (40) @(negedge clk);
    chk("pre-reset tx low", 32'(tx_v[0]), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async rst tx", 32'(tx_v[0]), 32'd1);
    chk("async rst busy", 32'({busy_v[0], baud_en_v[0]}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_pulse(0, 8'h0F);
    capture(0, 10, {2'b00, 1'b1, 8'h0F, 1'b0}, "after_rst_0f", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
